// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite control/status register file with byte enables, read-only registers and SLVERR decode.
// Latency: read AR->R two cycles, write AW+W->B two cycles; one transaction in flight at a time.
// Backpressure: B and R outputs hold stable until accepted; new requests wait in IDLE meanwhile.
module axi4_lite_regfile_slave #(
    parameter int                ADDR_WIDTH = 32,
    parameter int                DATA_WIDTH = 32,
    parameter int                NUM_REGS   = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RVALID,
    input  logic                    S_RREADY
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

    state_t                  state, state_nxt;
    logic                    aw_got, w_got, wr_pend;
    logic                    last_grant_wr;   // 0: read granted last (reset value), 1: write
    logic                    grant_wr, grant_rd;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_W-1:0]       w_strb;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;

    logic [ADDR_WIDTH-1:0]   wr_idx, rd_idx;
    logic                    wr_ro;
    logic [1:0]              wr_resp, rd_resp;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Low address bits select a byte within the word and are ignored.
    assign wr_idx  = aw_addr >> OFF;
    assign rd_idx  = S_ARADDR >> OFF;
    assign wr_resp = (({1'b0, wr_idx} >= (ADDR_WIDTH+1)'(NUM_REGS)) || wr_ro) ? 2'b10 : 2'b00;
    assign rd_resp = ({1'b0, rd_idx} >= (ADDR_WIDTH+1)'(NUM_REGS)) ? 2'b10 : 2'b00;

    // Write target read-only lookup and read word mux (out-of-range reads yield zero).
    always_comb begin
        wr_ro   = 1'b0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == ADDR_WIDTH'(i) && RO_MASK[i]) wr_ro = 1'b1;
            if (rd_idx == ADDR_WIDTH'(i)) rd_word = regs[i];
        end
    end

    // Next-state, arbitration and channel handshake outputs.
    always_comb begin
        state_nxt = state;
        S_AWREADY = 1'b0;
        S_WREADY  = 1'b0;
        S_BVALID  = 1'b0;
        S_BRESP   = 2'b00;
        S_ARREADY = 1'b0;
        S_RVALID  = 1'b0;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE: begin
                if ((S_AWVALID || S_WVALID) && (!S_ARVALID || !last_grant_wr)) begin
                    grant_wr  = 1'b1;
                    state_nxt = WRITE;
                end else if (S_ARVALID) begin
                    grant_rd  = 1'b1;
                    state_nxt = RADDR;
                end
            end
            WRITE: begin
                S_AWREADY = !aw_got;
                S_WREADY  = !w_got;
                if ((aw_got || S_AWVALID) && (w_got || S_WVALID)) state_nxt = WRESP;
            end
            WRESP: begin
                S_BVALID = 1'b1;
                S_BRESP  = wr_resp;
                if (S_BREADY) state_nxt = IDLE;
            end
            RADDR: begin
                S_ARREADY = 1'b1;
                if (S_ARVALID) state_nxt = RDATA;
            end
            RDATA: begin
                S_RVALID = 1'b1;
                if (S_RREADY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign aw_hs   = S_AWVALID && S_AWREADY;
    assign w_hs    = S_WVALID && S_WREADY;
    assign b_hs    = S_BVALID && S_BREADY;
    assign ar_hs   = S_ARVALID && S_ARREADY;
    assign r_hs    = S_RVALID && S_RREADY;
    assign S_RDATA = rdata_q;
    assign S_RRESP = rresp_q;

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Channel capture, arbitration history and registered read data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            wr_pend       <= 1'b0;
            last_grant_wr <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            rdata_q       <= '0;
            rresp_q       <= 2'b00;
        end else begin
            if (grant_wr) last_grant_wr <= 1'b1;
            if (grant_rd) last_grant_wr <= 1'b0;
            if (aw_hs) begin
                aw_addr <= S_AWADDR;
                aw_got  <= 1'b1;
            end
            if (w_hs) begin
                w_data <= S_WDATA;
                w_strb <= S_WSTRB;
                w_got  <= 1'b1;
            end
            // wr_pend marks the first WRESP cycle, the single commit point.
            if (state == WRITE && state_nxt == WRESP) wr_pend <= 1'b1;
            if (state == WRESP) wr_pend <= 1'b0;
            if (b_hs) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= rd_resp;
            end
            if (r_hs) begin
                rdata_q <= '0;
                rresp_q <= 2'b00;
            end
        end
    end

    // Register array: byte-lane commit at the end of the first WRESP cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (state == WRESP && wr_pend) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == ADDR_WIDTH'(i) && !RO_MASK[i]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave: latency, strobes, decode errors, arbitration, reset.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Every wait on the DUT is bounded; an expired bound counts as a failed check.
module tb_axi4_lite_regfile_slave;
    logic        ACLK, ARESET;
    logic [31:0] S_AWADDR, S_WDATA, S_ARADDR, S_RDATA;
    logic [3:0]  S_WSTRB;
    logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
    logic [1:0]  S_BRESP, S_RRESP;
    int          errors = 0;
    int          checks = 0;

    axi4_lite_regfile_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(32), .RO_MASK(32'h0000_0020)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic do_reset();
        ARESET = 1'b1;
        S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0; S_BREADY = 0; S_RREADY = 0;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit to);
        bit af, wf, bf;
        S_AWADDR = a; S_AWVALID = 1; S_WDATA = d; S_WSTRB = s; S_WVALID = 1; S_BREADY = 1;
        to = 1; resp = 2'b11;
        for (int n = 0; n < 40; n++) begin
            @(negedge ACLK);
            af = S_AWVALID && S_AWREADY; wf = S_WVALID && S_WREADY; bf = S_BVALID;
            if (bf) resp = S_BRESP;
            @(posedge ACLK); #1;
            if (af) S_AWVALID = 0;
            if (wf) S_WVALID = 0;
            if (bf) begin to = 0; break; end
        end
        S_AWVALID = 0; S_WVALID = 0; S_BREADY = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output bit to);
        bit arf, rf;
        S_ARADDR = a; S_ARVALID = 1; S_RREADY = 1;
        to = 1; d = 32'hxxxx_xxxx; resp = 2'b11;
        for (int n = 0; n < 40; n++) begin
            @(negedge ACLK);
            arf = S_ARVALID && S_ARREADY; rf = S_RVALID;
            if (rf) begin d = S_RDATA; resp = S_RRESP; end
            @(posedge ACLK); #1;
            if (arf) S_ARVALID = 0;
            if (rf) begin to = 0; break; end
        end
        S_ARVALID = 0; S_RREADY = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge ACLK);
        checks++;
        if ({S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID} !== 5'b0) begin
            errors++; $display("FAIL reset_handshakes: got %b expected 00000",
                               {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID});
        end
        checks++;
        if (S_RDATA !== 32'h0 || S_RRESP !== 2'b00 || S_BRESP !== 2'b00) begin
            errors++; $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b expected 0/00/00",
                               S_RDATA, S_RRESP, S_BRESP);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_write_same_cycle();
        S_AWADDR = 32'h0C; S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'hF;
        S_AWVALID = 1; S_WVALID = 1; S_BREADY = 1;
        @(negedge ACLK);
        checks++;
        if (S_AWREADY !== 1'b0 || S_WREADY !== 1'b0) begin
            errors++; $display("FAIL wr_cycle0_ready: got aw=%b w=%b expected 0 0", S_AWREADY, S_WREADY);
        end
        @(posedge ACLK); #1;
        @(negedge ACLK);
        checks++;
        if (S_AWREADY !== 1'b1 || S_WREADY !== 1'b1 || S_BVALID !== 1'b0) begin
            errors++; $display("FAIL wr_cycle1_ready: got aw=%b w=%b b=%b expected 1 1 0",
                               S_AWREADY, S_WREADY, S_BVALID);
        end
        @(posedge ACLK); #1;
        S_AWVALID = 0; S_WVALID = 0;
        @(negedge ACLK);
        checks++;
        if (S_BVALID !== 1'b1 || S_BRESP !== 2'b00) begin
            errors++; $display("FAIL wr_cycle2_bvalid: got bvalid=%b bresp=%b expected 1 00", S_BVALID, S_BRESP);
        end
        @(posedge ACLK); #1;
        S_BREADY = 0;
        @(negedge ACLK);
        checks++;
        if (S_BVALID !== 1'b0) begin
            errors++; $display("FAIL wr_b_drop: got bvalid=%b expected 0", S_BVALID);
        end
        // Read back with latency checks.
        @(posedge ACLK); #1;
        S_ARADDR = 32'h0C; S_ARVALID = 1; S_RREADY = 1;
        @(negedge ACLK);
        checks++;
        if (S_ARREADY !== 1'b0) begin
            errors++; $display("FAIL rd_cycle0_ready: got %b expected 0", S_ARREADY);
        end
        @(posedge ACLK); #1;
        @(negedge ACLK);
        checks++;
        if (S_ARREADY !== 1'b1 || S_RVALID !== 1'b0) begin
            errors++; $display("FAIL rd_cycle1: got arready=%b rvalid=%b expected 1 0", S_ARREADY, S_RVALID);
        end
        @(posedge ACLK); #1;
        S_ARVALID = 0;
        @(negedge ACLK);
        checks++;
        if (S_RVALID !== 1'b1 || S_RDATA !== 32'hDEADBEEF || S_RRESP !== 2'b00) begin
            errors++; $display("FAIL rd_cycle2_data: got rvalid=%b rdata=%h rresp=%b expected 1 deadbeef 00",
                               S_RVALID, S_RDATA, S_RRESP);
        end
        @(posedge ACLK); #1;
        S_RREADY = 0;
        @(negedge ACLK);
        checks++;
        if (S_RVALID !== 1'b0 || S_RDATA !== 32'h0) begin
            errors++; $display("FAIL rd_exit_clear: got rvalid=%b rdata=%h expected 0 00000000", S_RVALID, S_RDATA);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_w_before_aw();
        int bcnt = 0;
        bit af, wf;
        logic [31:0] d;
        logic [1:0]  r;
        bit to;
        S_WDATA = 32'h11223344; S_WSTRB = 4'b0101; S_WVALID = 1; S_BREADY = 1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge ACLK);
            af = S_AWVALID && S_AWREADY; wf = S_WVALID && S_WREADY;
            if (S_BVALID) bcnt++;
            @(posedge ACLK); #1;
            if (af) S_AWVALID = 0;
            if (wf) S_WVALID = 0;
            if (cyc == 2) begin S_AWADDR = 32'h0C; S_AWVALID = 1; end
        end
        S_AWVALID = 0; S_WVALID = 0; S_BREADY = 0;
        checks++;
        if (bcnt !== 1) begin
            errors++; $display("FAIL w_first_bcount: got %0d bvalid cycles expected 1", bcnt);
        end
        axi_read(32'h0C, d, r, to);
        checks++;
        if (to || d !== 32'hDE22BE44 || r !== 2'b00) begin
            errors++; $display("FAIL strobe_merge: got rdata=%h rresp=%b timeout=%0d expected de22be44 00 0", d, r, to);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0]  r;
        bit to;
        axi_read(32'h80, d, r, to);
        checks++;
        if (to || d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("FAIL rd_out_of_range: got rdata=%h rresp=%b timeout=%0d expected 0 10", d, r, to);
        end
        axi_write(32'h80, 32'hFFFFFFFF, 4'hF, r, to);
        checks++;
        if (to || r !== 2'b10) begin
            errors++; $display("FAIL wr_out_of_range: got bresp=%b timeout=%0d expected 10", r, to);
        end
        axi_read(32'h00, d, r, to);
        checks++;
        if (to || d !== 32'h0) begin
            errors++; $display("FAIL oor_reg0_untouched: got %h expected 00000000", d);
        end
        axi_read(32'h0C, d, r, to);
        checks++;
        if (to || d !== 32'hDE22BE44) begin
            errors++; $display("FAIL oor_reg3_untouched: got %h expected de22be44", d);
        end
    endtask

    task automatic test_read_only();
        logic [31:0] d;
        logic [1:0]  r;
        bit to;
        axi_write(32'h14, 32'hFFFFFFFF, 4'hF, r, to);
        checks++;
        if (to || r !== 2'b10) begin
            errors++; $display("FAIL ro_bresp: got %b timeout=%0d expected 10", r, to);
        end
        axi_read(32'h14, d, r, to);
        checks++;
        if (to || d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL ro_readback: got rdata=%h rresp=%b expected 0 00", d, r);
        end
    endtask

    task automatic test_reset_in_wresp();
        bit seen = 0;
        bit af, wf;
        logic [31:0] d;
        logic [1:0]  r;
        bit to;
        S_AWADDR = 32'h18; S_WDATA = 32'hCAFEF00D; S_WSTRB = 4'hF;
        S_AWVALID = 1; S_WVALID = 1; S_BREADY = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK);
            if (S_BVALID) begin seen = 1; break; end
            af = S_AWVALID && S_AWREADY; wf = S_WVALID && S_WREADY;
            @(posedge ACLK); #1;
            if (af) S_AWVALID = 0;
            if (wf) S_WVALID = 0;
        end
        S_AWVALID = 0; S_WVALID = 0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rst_wresp_reach: bvalid never seen expected within 20 cycles");
        end
        @(posedge ACLK); #1;
        @(negedge ACLK);
        checks++;
        if (S_BVALID !== 1'b1 || S_BRESP !== 2'b00) begin
            errors++; $display("FAIL b_backpressure: got bvalid=%b bresp=%b expected 1 00", S_BVALID, S_BRESP);
        end
        ARESET = 1'b1;
        #1;
        checks++;
        if (S_BVALID !== 1'b0) begin
            errors++; $display("FAIL rst_async_bvalid: got %b expected 0", S_BVALID);
        end
        @(posedge ACLK); #1 ARESET = 1'b0;
        axi_read(32'h18, d, r, to);
        checks++;
        if (to || d !== 32'h0) begin
            errors++; $display("FAIL rst_reg_cleared: got %h timeout=%0d expected 00000000", d, to);
        end
        axi_write(32'h18, 32'h0BADCAFE, 4'hF, r, to);
        checks++;
        if (to || r !== 2'b00) begin
            errors++; $display("FAIL post_rst_write: got bresp=%b timeout=%0d expected 00", r, to);
        end
        axi_read(32'h18, d, r, to);
        checks++;
        if (to || d !== 32'h0BADCAFE || r !== 2'b00) begin
            errors++; $display("FAIL post_rst_read: got rdata=%h rresp=%b expected 0badcafe 00", d, r);
        end
    endtask

    task automatic test_arbitration();
        logic [7:0] seq [4];
        logic [7:0] exp_seq [4];
        int nev = 0;
        int stall = 0;
        exp_seq[0] = "W"; exp_seq[1] = "R"; exp_seq[2] = "W"; exp_seq[3] = "R";
        for (int k = 0; k < 4; k++) seq[k] = "?";
        do_reset();
        S_AWADDR = 32'h10; S_WDATA = 32'hA5A50001; S_WSTRB = 4'hF; S_ARADDR = 32'h10;
        S_AWVALID = 1; S_WVALID = 1; S_ARVALID = 1; S_BREADY = 1; S_RREADY = 0;
        for (int cyc = 0; cyc < 80 && nev < 4; cyc++) begin
            @(negedge ACLK);
            if (S_BVALID && S_BREADY) begin seq[nev] = "W"; nev++; end
            if (S_RVALID && S_RREADY && nev < 4) begin seq[nev] = "R"; nev++; end
            if (S_RVALID && !S_RREADY) begin
                checks++;
                if (S_RDATA !== 32'hA5A50001 || S_RRESP !== 2'b00) begin
                    errors++; $display("FAIL r_stall_stable: stall %0d got rdata=%h rresp=%b expected a5a50001 00",
                                       stall, S_RDATA, S_RRESP);
                end
                stall++;
            end
            if (nev < 4) begin
                @(posedge ACLK); #1;
                if (stall == 4) S_RREADY = 1;
            end
        end
        S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0;
        @(posedge ACLK); #1;
        S_BREADY = 0; S_RREADY = 0;
        repeat (2) @(posedge ACLK);
        #1;
        checks++;
        if (nev !== 4 || stall !== 4) begin
            errors++; $display("FAIL arb_progress: got %0d grants %0d stalls expected 4 4", nev, stall);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seq[k] !== exp_seq[k]) begin
                errors++; $display("FAIL arb_order[%0d]: got %s expected %s", k, seq[k], exp_seq[k]);
            end
        end
    endtask

    initial begin
        ARESET = 1'b1;
        S_AWADDR = 0; S_WDATA = 0; S_WSTRB = 0; S_ARADDR = 0;
        S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0; S_BREADY = 0; S_RREADY = 0;
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_slverr();
        test_read_only();
        test_reset_in_wresp();
        test_arbitration();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
